// File: rtl/pipeline_pkg.sv
// Shared pipeline types: in-flight writer entry, forwarding constants and
// the select-width helper used by the hazard/forwarding controller.
package pipeline_pkg;

    // Widest register index an entry can track; narrower indices are zero-extended.
    localparam int REG_AW_MAX = 8;

    localparam int FWD_RF = 0;

    typedef struct packed {
        logic                  valid;
        logic [REG_AW_MAX-1:0] rd;
        logic                  regwrite;
        logic                  is_load;
    } entry_t;

    function automatic int sel_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fwd_src_select.sv
// Youngest-match priority encoder for one source operand over the
// in-flight writer table; also flags a load that is not yet forwardable.
module fwd_src_select
    import pipeline_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int REG_AW     = 5,
    parameter int LOAD_STAGE = 2,
    parameter int SW         = 2
) (
    input  entry_t [DEPTH:1]  tbl,
    input  logic              src_used,
    input  logic [REG_AW-1:0] rs,
    output logic [SW-1:0]     sel,
    output logic              load_hazard
);

    logic [REG_AW_MAX-1:0] rs_ext;
    logic                  found;

    assign rs_ext = REG_AW_MAX'(rs);

    always_comb begin
        sel         = SW'(FWD_RF);
        load_hazard = 1'b0;
        found       = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            if (!found && src_used && tbl[k].valid && tbl[k].regwrite &&
                (tbl[k].rd != '0) && (tbl[k].rd == rs_ext)) begin
                found       = 1'b1;
                sel         = SW'(k);
                load_hazard = tbl[k].is_load && (k < LOAD_STAGE);
            end
        end
    end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard/forwarding controller: tracks producers issued into EX, raises the
// load-use stall and registers per-operand forwarding selects for EX.
module hazard_fwd_ctrl
    import pipeline_pkg::*;
#(
    parameter  int NSRC       = 2,
    parameter  int DEPTH      = 2,
    parameter  int REG_AW     = 5,
    parameter  int LOAD_STAGE = 2,
    localparam int SW         = sel_width(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   hold,
    input  logic                   flush,
    input  logic                   id_valid,
    input  logic [REG_AW-1:0]      id_rd,
    input  logic                   id_regwrite,
    input  logic                   id_is_load,
    input  logic [NSRC-1:0]        id_src_used,
    input  logic [NSRC*REG_AW-1:0] id_rs,
    output logic                   stall,
    output logic [NSRC*SW-1:0]     fwd_sel,
    output logic [15:0]            stall_count
);

    entry_t [DEPTH:1]   st;
    entry_t             id_entry;
    logic [NSRC*SW-1:0] sel_next;
    logic [NSRC-1:0]    load_hz;
    logic               raw_stall;
    logic               enter;

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        fwd_src_select #(
            .DEPTH      (DEPTH),
            .REG_AW     (REG_AW),
            .LOAD_STAGE (LOAD_STAGE),
            .SW         (SW)
        ) u_sel (
            .tbl         (st),
            .src_used    (id_src_used[i]),
            .rs          (id_rs[i*REG_AW +: REG_AW]),
            .sel         (sel_next[i*SW +: SW]),
            .load_hazard (load_hz[i])
        );
    end

    assign raw_stall = |load_hz;
    // Flush and hold both suppress the stall: a flushed instruction never
    // needs its operands, and a frozen pipeline cannot take the bubble.
    assign stall     = raw_stall & id_valid & ~flush & ~hold;
    assign enter     = id_valid & ~stall & ~flush;

    always_comb begin
        id_entry          = '0;
        id_entry.valid    = 1'b1;
        id_entry.rd       = REG_AW_MAX'(id_rd);
        id_entry.regwrite = id_regwrite;
        id_entry.is_load  = id_is_load;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st          <= '0;
            fwd_sel     <= '0;
            stall_count <= '0;
        end else if (!hold) begin
            for (int k = 2; k <= DEPTH; k++) begin
                st[k] <= st[k-1];
            end
            st[1]   <= enter ? id_entry : '0;
            fwd_sel <= enter ? sel_next : '0;
            if (stall && (stall_count != 16'hFFFF)) begin
                stall_count <= stall_count + 16'd1;
            end
        end
    end

endmodule

// File: doc/hazard_fwd_ctrl.md
# hazard_fwd_ctrl

Parametrised hazard and forwarding controller for the pipelined core. It replaces the purely combinational EX-stage forwarding check with a tracked in-flight-writer table. It sits between ID and EX: it records each instruction issued into EX, compares the ID-stage source registers against all tracked producers, and drives a combinational load-use stall toward IF/ID. It also drives registered forwarding selects that arrive with the consumer at EX, generalised to NSRC operands and DEPTH forwarding stages.

## Interface
- NSRC, 2, number of source operands checked per instruction
- DEPTH, 2, forwarding stages after EX (1 = EX/MEM, 2 = MEM/WB, ...)
- REG_AW, 5, register index width
- LOAD_STAGE, 2, lowest select index at which load data is forwardable (1..DEPTH)
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- hold  in  1  global pipeline freeze (e.g. memory wait)
- flush  in  1  kill the instruction currently in ID (bubble into EX)
- id_valid  in  1  ID holds a real instruction
- id_rd  in  REG_AW  ID destination register
- id_regwrite  in  1  ID instruction writes rd
- id_is_load  in  1  ID instruction is a load
- id_src_used  in  NSRC  per-operand "reads register" flag
- id_rs  in  NSRC*REG_AW  source indices, operand i at [i*REG_AW +: REG_AW]
- stall  out  1  combinational load-use stall: freeze PC and IF/ID, bubble into EX
- fwd_sel  out  NSRC*SW  registered per-operand select for EX; SW = $clog2(DEPTH+1); 0 = register file, k = stage k
- stall_count  out  16  saturating count of stall cycles

## Operation
- Table st[1..DEPTH] holds entries of {valid, rd, regwrite, is_load}; st[1] = instruction now in EX, st[k] = k-1 stages further on.
- A producer entry "matches" operand i when all of the following hold: valid, regwrite, rd != 0, id_src_used[i], rd == rs_i.
- For each operand, only the youngest match counts: the lowest k wins and older matches are ignored.
- Raw stall: any operand's youngest match has is_load = 1 and k < LOAD_STAGE.
- stall = raw stall & id_valid & ~flush & ~hold.
- Register file is write-before-read. A producer leaving st[DEPTH] needs no forwarding.
- Advance when hold = 0:
  - st[k] <= st[k-1] for k = 2..DEPTH.
  - st[1] <= ID instruction if id_valid & ~stall & ~flush; otherwise st[1] <= bubble (valid = 0).
- fwd_sel_q[i] <= youngest-match k if the ID instruction enters EX; otherwise 0.
- When hold = 1, the table, fwd_sel and stall_count are frozen, and flush is ignored.
- stall_count increments on every cycle with stall = 1 and saturates at 16'hFFFF.

## Timing
- stall: combinational from inputs and the table, same cycle.
- fwd_sel: 1-cycle latency, valid during the consumer's EX cycle.
- With LOAD_STAGE = 2, a load immediately followed by a dependent instruction gives exactly 1 stall cycle; the consumer then sees sel = 2.
- Flush and stall together: flush wins, stall = 0, and a bubble enters EX.
- Reset state (asynchronous): all table entries valid = 0, fwd_sel = 0, stall = 0, stall_count = 0.
- Reset mid-operation: all tracked producers are discarded immediately. The first cycle after reset release never stalls.

## Structure
- Shared pipeline_pkg holds:
  - the entry struct {valid, rd, regwrite, is_load};
  - FWD_RF = 0;
  - a function computing SW from DEPTH.
- Sub-module fwd_src_select is instantiated NSRC times. Each instance is a combinational youngest-match priority encoder over the table and outputs {sel, load_hazard}.
- The top level owns the table shift, the fwd_sel register, stall generation and the counter.

## Test plan
- Reset with rst_n = 0 mid-stream -> stall = 0, fwd_sel = 0, stall_count = 0 immediately; the next dependent instruction gets sel = 0.
- `add x5` then `sub` reading rs1 = x5 -> stall = 0; sel[0] = 1 in the sub's EX cycle; with one instruction between them, sel[0] = 2.
- `lw x7` then `add` reading rs2 = x7 -> exactly 1 cycle of stall = 1; the bubble enters EX; sel[1] = 2; stall_count = 1.
- `add x3`, `add x3`, then a consumer of x3 -> sel = 1 (youngest wins); for a write to x0, sel = 0 and there is no stall.
- Load-use with flush = 1 in the same cycle -> stall = 0; st[1] is a bubble; stall_count is unchanged.
- hold = 1 for 3 cycles during a load-use -> table, fwd_sel and stall_count are frozen and stall = 0 throughout; after hold drops, a single stall cycle follows.
